// File: rtl/g_sensor_sample_sequencer.sv
// Interrupt-driven accelerometer sampler: reads X/Y/Z over a valid/ready command
// port into a word FIFO that the CPU drains through an Avalon-MM slave.
module g_sensor_sample_sequencer #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [5:0] AXIS_BASE  = 6'h32,
    parameter int         TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        int_in,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [5:0]  cmd_addr,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_data
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        state;
    logic [1:0]    axis;
    logic [TW-1:0] timer;
    logic [15:0]   count;
    logic          s1, s2, s3;
    logic          enable, irq_en, pending, done, overflow, timeout_flag;

    logic [15:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;

    logic bus_rd, bus_wr, int_edge, soft_trig, trigger;
    logic fifo_empty, fifo_full, pop, push_req, push, push_drop, busy;
    logic status_wr;
    logic [1:0]  axis_n;
    logic [8:0]  level_ext;
    logic [7:0]  level_byte;
    logic [15:0] status_word;
    logic        unused_wdata;

    assign bus_rd    = chipselect & ~read_n;
    assign bus_wr    = chipselect & ~write_n;
    assign status_wr = bus_wr & (address == 2'd1);
    assign int_edge  = s2 & ~s3;
    assign soft_trig = bus_wr & (address == 2'd0) & writedata[2];
    assign trigger   = (int_edge | soft_trig) & enable;
    assign busy      = (state != S_IDLE);
    assign axis_n    = axis + 2'd1;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign pop        = bus_rd & (address == 2'd2) & ~fifo_empty;
    assign push_req   = (state == S_WAIT) & rsp_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push       = push_req & (~fifo_full | pop);
    assign push_drop  = push_req & fifo_full & ~pop;

    assign level_ext   = 9'(level);
    assign level_byte  = level_ext[8] ? 8'hFF : level_ext[7:0];
    assign status_word = {level_byte, 3'b000, timeout_flag, overflow, done, pending, busy};
    assign irq         = irq_en & (done | overflow | timeout_flag);
    assign unused_wdata = &{1'b0, writedata[31:5]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep each flop sampling the old value of the previous stage.
            s1 <= int_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            axis         <= 2'd0;
            timer        <= '0;
            count        <= 16'd0;
            cmd_valid    <= 1'b0;
            cmd_addr     <= 6'd0;
            pending      <= 1'b0;
            done         <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            if (status_wr && writedata[2]) done         <= 1'b0;
            if (status_wr && writedata[4]) timeout_flag <= 1'b0;
            if (trigger && busy)           pending      <= 1'b1;

            // Hardware sets below come after the write-clears so they win.
            case (state)
                S_IDLE: begin
                    if (trigger || pending) begin
                        pending   <= 1'b0;
                        axis      <= 2'd0;
                        cmd_valid <= 1'b1;
                        cmd_addr  <= AXIS_BASE;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        timer     <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        if (axis == 2'd2) begin
                            count <= count + 16'd1;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            axis      <= axis_n;
                            cmd_valid <= 1'b1;
                            cmd_addr  <= AXIS_BASE + {3'b000, axis_n, 1'b0};
                            state     <= S_REQ;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        timeout_flag <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (!enable) pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            readdata <= 32'd0;
        end else begin
            if (bus_wr && address == 2'd0) begin
                enable <= writedata[0];
                irq_en <= writedata[1];
            end
            if (status_wr && writedata[3]) overflow <= 1'b0;
            if (push_drop)                 overflow <= 1'b1;

            if (bus_rd) begin
                case (address)
                    2'd0: readdata <= {30'd0, irq_en, enable};
                    2'd1: readdata <= {16'd0, status_word};
                    2'd2: readdata <= fifo_empty ? 32'd0 : {16'd0, mem[rd_ptr]};
                    2'd3: readdata <= {16'd0, count};
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rsp_data;
    end

endmodule

// File: tb/tb_g_sensor_sample_sequencer.sv
// Self-checking bench: register tables per phase, a FIFO scoreboard and
// hand-written sequences for handshake, pending, timeout, overflow and reset.
module tb_g_sensor_sample_sequencer;

    localparam int DEPTH = 8;
    localparam int TMO   = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [31:0] writedata, readdata;
    logic        irq, int_in, cmd_valid, cmd_ready, rsp_valid;
    logic [5:0]  cmd_addr;
    logic [15:0] rsp_data;

    g_sensor_sample_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .AXIS_BASE (6'h32),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .read_n    (read_n),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .int_in    (int_in),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          phase;
        logic [1:0]  addr;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t    tbl[16];
    int          n_vec = 0;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int p, input logic [1:0] a, input logic [31:0] e);
        tbl[n_vec] = '{phase: p, addr: a, exp: e};
        n_vec++;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] e, input string name);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, e);
    endtask

    task automatic run_phase(input int p);
        for (int i = 0; i < n_vec; i++)
            if (tbl[i].phase == p)
                read_check(tbl[i].addr, tbl[i].exp, $sformatf("p%0d_reg%0d", p, tbl[i].addr));
    endtask

    task automatic pop_check(input string name);
        logic [31:0] d;
        logic [31:0] e;
        e = (sb_q.size() == 0) ? 32'd0 : {16'd0, sb_q.pop_front()};
        bus_read(2'd2, d);
        check(name, d, e);
    endtask

    // Acts as the SPI engine for one command; optionally returns a response.
    task automatic serve(input logic [5:0] exp_addr, input logic [15:0] data,
                         input int ready_delay, input bit respond);
        int w = 0;
        bit stable = 1'b1;
        while (!cmd_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("cmd_valid_%0h", exp_addr), cmd_valid, 1);
        check($sformatf("cmd_addr_%0h", exp_addr), cmd_addr, exp_addr);
        if (ready_delay > 0) begin
            for (int i = 0; i < ready_delay; i++) begin
                @(negedge clk);
                if (cmd_valid !== 1'b1 || cmd_addr !== exp_addr) stable = 1'b0;
            end
            check("backpressure_stable", stable, 1);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check($sformatf("cmd_drop_%0h", exp_addr), cmd_valid, 0);
        if (respond) begin
            rsp_valid = 1'b1;
            rsp_data  = data;
            if (sb_q.size() < DEPTH) sb_q.push_back(data);
            @(negedge clk);
            rsp_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  seen;
        logic [31:0] d;

        add_vec(0, 2'd0, 32'h0);    add_vec(0, 2'd1, 32'h0);
        add_vec(0, 2'd2, 32'h0);    add_vec(0, 2'd3, 32'h0);
        add_vec(1, 2'd0, 32'h3);    add_vec(1, 2'd1, 32'h0304);
        add_vec(1, 2'd3, 32'h1);
        add_vec(2, 2'd0, 32'h3);    add_vec(2, 2'd1, 32'h0604);
        add_vec(2, 2'd3, 32'h3);
        add_vec(3, 2'd1, 32'h0010); add_vec(3, 2'd3, 32'h3);
        add_vec(4, 2'd1, 32'h080C); add_vec(4, 2'd3, 32'h6);
        add_vec(5, 2'd1, 32'h0);    add_vec(5, 2'd3, 32'h0);

        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        writedata = 32'd0; int_in = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 0);
        check("rst_irq", irq, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_addr", cmd_addr, 0);
        reset_n = 1'b1;
        run_phase(0);

        // Basic X/Y/Z sequence from an interrupt edge.
        bus_write(2'd0, 32'h3);
        int_in = 1'b1;
        serve(6'h32, 16'h0011, 0, 1'b1);
        serve(6'h34, 16'h0022, 0, 1'b1);
        serve(6'h36, 16'h0033, 0, 1'b1);
        int_in = 1'b0;
        @(negedge clk);
        check("seq_irq", irq, 1);
        run_phase(1);
        for (int i = 0; i < 3; i++) pop_check($sformatf("seq_data%0d", i));
        bus_write(2'd1, 32'h4);
        check("seq_irq_clr", irq, 0);

        // Soft trigger plus an interrupt edge while busy -> pending second run.
        bus_write(2'd0, 32'h7);
        serve(6'h32, 16'h0101, 0, 1'b1);
        int_in = 1'b1;
        repeat (5) @(negedge clk);
        read_check(2'd1, 32'h0103, "pending_set");
        int_in = 1'b0;
        serve(6'h34, 16'h0102, 0, 1'b1);
        serve(6'h36, 16'h0103, 0, 1'b1);
        serve(6'h32, 16'h0201, 0, 1'b1);
        serve(6'h34, 16'h0202, 0, 1'b1);
        serve(6'h36, 16'h0203, 0, 1'b1);
        repeat (2) @(negedge clk);
        run_phase(2);
        for (int i = 0; i < 6; i++) pop_check($sformatf("pend_data%0d", i));
        bus_write(2'd1, 32'h1C);

        // No response after the first accept -> timeout after TMO cycles.
        bus_write(2'd0, 32'h7);
        serve(6'h32, 16'h0, 0, 1'b0);
        cyc = 0;
        while (!irq && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc, TMO);
        rsp_valid = 1'b1; rsp_data = 16'hDEAD;
        @(negedge clk);
        rsp_valid = 1'b0;
        run_phase(3);
        bus_write(2'd1, 32'h10);
        check("timeout_irq_clr", irq, 0);

        // Three sequences without draining: ninth word is dropped.
        for (int s = 0; s < 3; s++) begin
            bus_write(2'd0, 32'h7);
            serve(6'h32, 16'(16'h1000 * (s + 1) + 1), (s == 0) ? 5 : 0, 1'b1);
            serve(6'h34, 16'(16'h1000 * (s + 1) + 2), 0, 1'b1);
            serve(6'h36, 16'(16'h1000 * (s + 1) + 3), 0, 1'b1);
        end
        repeat (2) @(negedge clk);
        run_phase(4);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovf_data%0d", i));
        pop_check("ovf_empty_read");
        read_check(2'd1, 32'h000C, "ovf_drained_status");

        // Disabled: an edge must not start a sequence.
        bus_write(2'd0, 32'h0);
        int_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_valid) seen = 1'b1;
        end
        check("disabled_no_cmd", seen, 0);
        int_in = 1'b0;

        // Reset while a command is outstanding.
        bus_write(2'd0, 32'h3);
        int_in = 1'b1;
        serve(6'h32, 16'h0ABC, 0, 1'b1);
        int_in = 1'b0;
        cyc = 0;
        while (!cmd_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("reset_pre_valid", cmd_valid, 1);
        reset_n = 1'b0;
        #1;
        check("reset_async_valid", cmd_valid, 0);
        check("reset_async_irq", irq, 0);
        check("reset_async_readdata", readdata, 0);
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        run_phase(5);
        pop_check("reset_fifo_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/g_sensor_sample_sequencer.md
Name: g_sensor_sample_sequencer

Overview:
Interrupt-driven accelerometer sampling controller. It synchronizes the g-sensor interrupt line and detects its rising edge. On each edge (or a software trigger) it issues three register-read commands (X, Y, Z) to the shared SPI command engine over a valid/ready handshake, and buffers the 16-bit results in a word FIFO. The CPU drains the FIFO through an Avalon-MM slave with registered readdata and a level irq.

Parameters:
FIFO_DEPTH, 16, word FIFO entries; power of 2, range 4..256
AXIS_BASE, 6'h32, sensor register address of X axis; Y = base+2, Z = base+4
TIMEOUT, 1023, max cycles waiting for rsp_valid after command accept

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  slave word address
chipselect  in  1  slave select
read_n  in  1  active-low read strobe
write_n  in  1  active-low write strobe
writedata  in  32  slave write data
readdata  out  32  registered read data, valid cycle after read strobe
irq  out  1  level interrupt to CPU
int_in  in  1  raw g-sensor interrupt pin, asynchronous
cmd_valid  out  1  read command valid to SPI engine
cmd_ready  in  1  SPI engine accepts command
cmd_addr  out  6  sensor register address
rsp_valid  in  1  one-cycle read-data strobe
rsp_data  in  16  read result

Behaviour:
- Reset: readdata=0, irq=0, cmd_valid=0, cmd_addr=0, FSM IDLE, FIFO empty, all CTRL/STATUS bits 0, sample count 0.
- int_in path: 2-flop synchronizer (s1, s2) plus edge stage; edge = s2 & ~s3. Latency 3 clk from pin to edge.
- Register map:
  - addr0 CTRL rw: bit0 enable, bit1 irq_en. bit2 soft_trig: write-1 pulses a trigger and always reads 0.
  - addr1 STATUS: bit0 busy, bit1 pending, bit2 done, bit3 overflow, bit4 timeout, [15:8] FIFO level. Write-1-clears bits 2..4; other bits are ro.
  - addr2 DATA ro: [15:0] FIFO head. A read pops the FIFO; a read while empty returns 0 with no pop.
  - addr3 COUNT ro: [15:0] completed sample sets, wraps 0xFFFF->0.
  - Unused readdata bits are 0.
- Trigger = (edge | soft_trig) & enable. A trigger while disabled is discarded.
- FSM states:
  - IDLE: on trigger or pending, clear pending, axis=0, go to REQ.
  - REQ: cmd_valid=1, cmd_addr=AXIS_BASE+2*axis, held stable until cmd_ready. On cmd_valid&cmd_ready, drop cmd_valid the next cycle, clear the timer, go to WAIT.
  - WAIT: on rsp_valid, push rsp_data. If axis==2: count++, done=1, go to IDLE. Otherwise axis++ and go to REQ. If the timer reaches TIMEOUT before rsp_valid: timeout=1, go to IDLE, count unchanged, partial words stay in the FIFO.
- busy=1 in any state other than IDLE.
- Trigger while busy sets pending (one deep). Further triggers while pending=1 are lost and flagged as none.
- Clearing enable mid-sequence: the current sequence completes, pending is cleared, and no new start occurs.
- FIFO full on push: word dropped, overflow=1, no other state change.
- Push and pop in the same cycle: allowed when not full, level unchanged. When full, the pop happens first, so the push succeeds.
- irq = irq_en & (done | overflow | timeout), combinational from registered flags.
- Writes and hardware sets to the same flag in the same cycle: hardware set wins.
- rsp_valid outside WAIT is ignored.
- reset_n assertion mid-sequence returns everything to reset values immediately; cmd_valid deasserts asynchronously.

Test Plan:
- Sequence: CTRL=0x3, pulse int_in 0->1, cmd_ready=1, rsp_data=0x0011/0x0022/0x0033 -> cmd_addr 0x32,0x34,0x36 in order. Then irq=1, STATUS level=3, done=1, COUNT=1. DATA reads return 0x0011,0x0022,0x0033. Writing 0x4 to STATUS drops irq.
- Backpressure: cmd_ready low 5 cycles -> cmd_valid and cmd_addr stable all 5 cycles, exactly one command accepted.
- Pending trigger: soft trigger, plus int edge during axis 1 -> two full sequences back-to-back, COUNT=2, level=6, pending=0 at end.
- Timeout: TIMEOUT=15, no rsp after first accept -> at cycle 15 timeout=1, busy=0, COUNT=0, irq=1.
- Overflow: FIFO_DEPTH=4, two sequences with no drain -> level=4, overflow=1, 5th/6th words lost. Pop returns first 4 words.
- Disabled and reset: CTRL=0, int edge -> no cmd_valid. Assert reset_n low while in WAIT -> cmd_valid=0, STATUS=0, COUNT=0.
